// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the core's data-memory interface. It accepts one load or
//   store request at a time over a valid/ready request channel. After
//   LATENCY wait states it commits the access to an internal word array
//   and returns read data and error status over a valid/ready response
//   channel. Supports RV32I byte/halfword/word accesses with little-endian
//   byte lanes and load sign/zero extension.
//
// Parameters
//   DEPTH    number of 32-bit words in the array (power of 2, >= 4)
//   LATENCY  wait-state cycles between acceptance and response (0..15)
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   responder can accept a request (IDLE only)
//   req_we_i      1 = store, 0 = load
//   req_addr_i    byte address
//   req_wdata_i   store data, relevant bytes in the low bits
//   req_funct3_i  RV32I funct3 (size / sign)
//   rsp_valid_o   response present
//   rsp_ready_i   requester accepts response
//   rsp_rdata_o   load result; 0 for stores and errors
//   rsp_err_o     misaligned, out-of-range or illegal funct3
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, counting down wait states
// RESP  | access committed, response held until accepted

module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_hs;
    logic        w_commit;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic [3:0]  r_cnt;

    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hs         = 1'b0;
        w_commit     = 1'b0;
        // Gated with rst_n so ready is low while reset is held.
        req_ready_o  = (r_state == S_IDLE) && rst_n;
        rsp_valid_o  = (r_state == S_RESP);
        case (r_state)
            S_IDLE: begin
                w_hs = req_valid_i && req_ready_o;
                if (w_hs) begin
                    if (LAT4 != 4'd0) begin
                        w_state_next = S_WAIT;
                    end else begin
                        // No wait states: commit straight from the request inputs.
                        w_state_next = S_RESP;
                        w_commit     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = S_RESP;
                    w_commit     = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_cnt   <= '0;
        end else if (w_hs) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_f3    <= req_funct3_i;
            r_cnt   <= LAT4;
        end else if (r_state == S_WAIT) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Access decode: in IDLE the commit (LATENCY=0) uses the live inputs
    // ------------------------------------------------------------------
    logic        w_idle;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_f3;
    logic [1:0]  w_size;
    logic        w_illegal;
    logic        w_misal;
    logic        w_oor;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;

    assign w_idle  = (r_state == S_IDLE);
    assign w_we    = w_idle ? req_we_i     : r_we;
    assign w_addr  = w_idle ? req_addr_i   : r_addr;
    assign w_wdata = w_idle ? req_wdata_i  : r_wdata;
    assign w_f3    = w_idle ? req_funct3_i : r_f3;
    assign w_size  = w_f3[1:0];

    assign w_illegal = w_we ? (w_f3 >= 3'd3)
                            : ((w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7));
    assign w_misal   = ((w_size == 2'd1) && w_addr[0])
                    || ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));
    assign w_oor     = |w_addr[31:AW+2];
    assign w_err     = w_illegal || w_misal || w_oor;

    assign w_idx  = w_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[8*w_addr[1:0] +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    // funct3[2] set means unsigned (LBU/LHU).
    always_comb begin
        w_load = w_word;
        case (w_size)
            2'd0:    w_load = {{24{~w_f3[2] & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{~w_f3[2] & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        w_be    = 4'b1111;
        w_lanes = w_wdata;
        case (w_size)
            2'd0: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_lanes = {4{w_wdata[7:0]}};
            end
            2'd1: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = w_wdata;
            end
        endcase
    end

    // Array is not reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers: hold until the next commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
        end
    end

    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_funct3_i (req_funct3_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, expect the response one negedge after
    // the accepting edge's following edge (LATENCY=1), check it, accept it.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int cyc;
        @(negedge clk);
        chk({tag, ".req_ready"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_funct3_i = f3;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 32'd1);
        chk({tag, ".rdata"}, rsp_rdata_o, exp_rdata);
        chk({tag, ".err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk({tag, ".valid_clr"}, {31'd0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] held_rdata;
        rst_n        = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_funct3_i = '0;
        rsp_ready_i  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        chk("rst.err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst.req_ready", {31'd0, req_ready_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.ready_after", {31'd0, req_ready_o}, 32'd1);

        // Word store then read back
        txn("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0);
        txn("lw10", 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);

        // Byte store and byte loads with sign/zero extension
        txn("sb11",  1'b1, 32'h11, 32'h0000007F, 3'd0, 32'h0, 1'b0);
        txn("lb11",  1'b0, 32'h11, 32'h0, 3'd0, 32'h0000007F, 1'b0);
        txn("lw10b", 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD7FEF, 1'b0);
        txn("lbu13", 1'b0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 1'b0);
        txn("lb13",  1'b0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 1'b0);

        // Halfword store to upper half, signed/unsigned loads
        txn("sh16",  1'b1, 32'h16, 32'h00008001, 3'd1, 32'h0, 1'b0);
        txn("lh16",  1'b0, 32'h16, 32'h0, 3'd1, 32'hFFFF8001, 1'b0);
        txn("lhu16", 1'b0, 32'h16, 32'h0, 3'd5, 32'h00008001, 1'b0);

        // Errors
        txn("lw12_mis", 1'b0, 32'h12, 32'h0, 3'd2, 32'h0, 1'b1);
        txn("sw20",     1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 32'h0, 1'b0);
        txn("sh21_mis", 1'b1, 32'h21, 32'h0000ABCD, 3'd1, 32'h0, 1'b1);
        txn("lw20",     1'b0, 32'h20, 32'h0, 3'd2, 32'hCAFEF00D, 1'b0);
        txn("lw_oor",   1'b0, 32'h1000, 32'h0, 3'd2, 32'h0, 1'b1);
        txn("ld_f3_3",  1'b0, 32'h10, 32'h0, 3'd3, 32'h0, 1'b1);
        txn("st_f3_4",  1'b1, 32'h10, 32'h0, 3'd4, 32'h0, 1'b1);
        txn("lw10c",    1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD7FEF, 1'b0);

        // Backpressure: response held for 5 cycles, a stray request ignored
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_addr_i   = 32'h10;
        req_funct3_i = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall.latency", cyc, 32'd1);
        held_rdata = rsp_rdata_o;
        chk("stall.rdata0", held_rdata, 32'hDEAD7FEF);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid_i  = 1'b1;
                req_we_i     = 1'b1;
                req_addr_i   = 32'h10;
                req_wdata_i  = 32'h0;
                req_funct3_i = 3'd2;
            end else begin
                req_valid_i = 1'b0;
            end
            @(negedge clk);
            chk("stall.valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("stall.rdata", rsp_rdata_o, 32'hDEAD7FEF);
            chk("stall.err", {31'd0, rsp_err_o}, 32'd0);
            chk("stall.req_ready", {31'd0, req_ready_o}, 32'd0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("stall.valid_clr", {31'd0, rsp_valid_o}, 32'd0);
        chk("stall.ready_back", {31'd0, req_ready_o}, 32'd1);
        chk("stall.rdata_kept", rsp_rdata_o, 32'hDEAD7FEF);
        txn("lw10_after_stall", 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD7FEF, 1'b0);

        // Reset during WAIT drops the store
        txn("sw30", 1'b1, 32'h30, 32'h11111111, 3'd2, 32'h0, 1'b0);
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_addr_i   = 32'h30;
        req_wdata_i  = 32'h22222222;
        req_funct3_i = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("wrst.valid_in", {31'd0, rsp_valid_o}, 32'd0);
        chk("wrst.ready_in", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("wrst.valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("wrst.ready", {31'd0, req_ready_o}, 32'd1);
        txn("lw30", 1'b0, 32'h30, 32'h0, 3'd2, 32'h11111111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
